// File: rtl/gray_pkg.sv
//------------------------------------------------------------------------------
// Module  : gray_pkg
// Brief   : Shared width constant and binary/Gray conversion helpers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gray_pkg;

  localparam int GRAY_WIDTH = 3;

  function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] gray);
    logic [GRAY_WIDTH-1:0] bin;
    bin[GRAY_WIDTH-1] = gray[GRAY_WIDTH-1];
    for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_counter_if.sv
//------------------------------------------------------------------------------
// Module  : gray_counter_if
// Brief   : Enable / code / overflow bundle between the counter and its user.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gray_counter_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
);

  logic             En;
  logic [WIDTH-1:0] Output;
  logic             Overflow;

  modport master (
    output En,
    input  Output,
    input  Overflow
  );

  modport slave (
    input  En,
    output Output,
    output Overflow
  );

endinterface

`default_nettype wire

// File: rtl/gray_encode.sv
//------------------------------------------------------------------------------
// Module  : gray_encode
// Brief   : Combinational WIDTH-bit binary to reflected Gray converter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_encode #(
  parameter int WIDTH = 3
) (
  input  wire logic [WIDTH-1:0] i_bin,
  output logic      [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

`default_nettype wire

// File: rtl/gray_counter.sv
//------------------------------------------------------------------------------
// Module  : gray_counter
// Brief   : Enabled up-counter with Gray-coded output and sticky wrap flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  wire logic     Clk,
  input  wire logic     Reset,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] gray;

  always_comb begin
    bin_d = bin_q;
    ovf_d = ovf_q;
    if (bus.En) begin
      bin_d = bin_q + C_ONE;
      // Last code about to roll back to zero; the flag is sticky until reset.
      if (&bin_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      ovf_q <= ovf_d;
    end
  end

  gray_encode #(
    .WIDTH (WIDTH)
  ) u_gray_encode (
    .i_bin  (bin_q),
    .o_gray (gray)
  );

  assign bus.Output   = gray;
  assign bus.Overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_counter.sv
//------------------------------------------------------------------------------
// Module  : tb_gray_counter
// Brief   : Directed bench for gray_counter with hand-computed code sequence.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gray_counter;
  import gray_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  gray_counter_if #(.WIDTH(3)) bus ();

  gray_counter #(.WIDTH(3)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive inputs, take one rising edge, and return at the following falling edge.
  task automatic step(input logic r, input logic e);
    rst    = r;
    bus.En = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] seq [8];
  logic [2:0] prev;

  initial begin
    seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b010; seq[3] = 3'b110;
    seq[4] = 3'b111; seq[5] = 3'b101; seq[6] = 3'b100; seq[7] = 3'b000;
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    bus.En  = 1'b1;

    step(1'b1, 1'b1);
    check("reset_out", 32'(bus.Output), 32'h0);
    check("reset_ovf", 32'(bus.Overflow), 32'h0);

    prev = bus.Output;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1);
      check("count_out", 32'(bus.Output), 32'(seq[i]));
      check("count_ovf", 32'(bus.Overflow), 32'h0);
      check("one_bit", 32'($countones(bus.Output ^ prev)), 32'd1);
      check("monotonic", 32'(gray2bin(bus.Output)), 32'(i + 1));
      prev = bus.Output;
    end

    step(1'b0, 1'b1);
    check("wrap_out", 32'(bus.Output), 32'h0);
    check("wrap_ovf", 32'(bus.Overflow), 32'h1);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1);
      check("sticky_out", 32'(bus.Output), 32'(seq[i]));
      check("sticky_ovf", 32'(bus.Overflow), 32'h1);
    end

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("pre_hold_out", 32'(bus.Output), 32'h3);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check("hold_out", 32'(bus.Output), 32'h3);
      check("hold_ovf", 32'(bus.Overflow), 32'h1);
    end
    step(1'b0, 1'b1);
    check("resume_out", 32'(bus.Output), 32'h2);

    step(1'b0, 1'b1);
    check("pre_rst_out", 32'(bus.Output), 32'h6);
    check("pre_rst_ovf", 32'(bus.Overflow), 32'h1);
    step(1'b1, 1'b1);
    check("mid_rst_out", 32'(bus.Output), 32'h0);
    check("mid_rst_ovf", 32'(bus.Overflow), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check("rst_hold_out", 32'(bus.Output), 32'h0);
      check("rst_hold_ovf", 32'(bus.Overflow), 32'h0);
    end

    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1);
    end
    check("last_code", 32'(bus.Output), 32'h4);
    check("last_ovf", 32'(bus.Overflow), 32'h0);
    step(1'b1, 1'b1);
    check("prio_out", 32'(bus.Output), 32'h0);
    check("prio_ovf", 32'(bus.Overflow), 32'h0);
    step(1'b0, 1'b1);
    check("after_prio_out", 32'(bus.Output), 32'h1);
    check("after_prio_ovf", 32'(bus.Overflow), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous up-counter whose output is the reflected Gray-code encoding of an internal binary count, with a sticky wrap-around flag.
- Used as a small general-purpose sequencer and counter in the datapath. It advances one code per enabled clock edge.
- Default width is 3 bits, so the counter runs through 8 codes per cycle of the sequence.

Parameters:
- WIDTH, 3, number of code bits; must be >= 2.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  count enable; sampled on the rising edge of Clk.
- Output  output  WIDTH  current Gray code, equal to bin ^ (bin >> 1).
- Overflow  output  1  sticky flag set on wrap-around from the last code back to code 0.

Behaviour:
- Internal state:
  - bin: WIDTH-bit binary count register.
  - ovf: 1-bit register.
  - Output is combinational Gray encoding of bin.
  - Overflow = ovf.
  - No other state.
- Reset (synchronous, active-high): at a rising edge with Reset=1, bin <= 0 and ovf <= 0.
  - Output becomes all zeros and Overflow becomes 0 after that edge.
  - Reset has priority over En.
  - Reset asserted mid-sequence clears the count immediately at the next edge, whatever En is.
- Before the first reset, register contents are undefined. No power-on value is guaranteed.
- Count: at a rising edge with Reset=0 and En=1, bin <= bin + 1, modulo 2^WIDTH.
  - Output therefore changes in exactly one bit per step.
  - 3-bit sequence: 000, 001, 011, 010, 110, 111, 101, 100, then back to 000.
- Hold: at a rising edge with Reset=0 and En=0, bin and ovf keep their values.
- Wrap-around: when bin is all ones (Output = 100 for WIDTH=3), En=1 and Reset=0 at an edge:
  - bin wraps to 0.
  - ovf <= 1 on the same edge.
- Overflow latency: Overflow rises in the same cycle Output returns to 000.
- Overflow is sticky: it stays 1 through further counting and further wraps. Only Reset clears it.
- Latency: 1 clock from enabled edge to new Output. Output has no combinational path from En or Reset; it depends only on registered state.
- Simultaneous Reset=1 and En=1 with bin all ones: reset wins, so Overflow = 0 and Output = 000.

Decomposition:
- Shared package gray_pkg holds:
  - Default width constant GRAY_WIDTH = 3.
  - Pure function bin2gray(bin), returning bin ^ (bin >> 1).
  - Reference function gray2bin, used by benches to check monotonic counting.
- One natural sub-module, gray_encode: purely combinational WIDTH-bit binary-to-Gray converter, instantiated by gray_counter on the bin register.
- Counter and overflow registers stay in gray_counter.

Test Plan:
- Reset=1 for one edge with En=1 -> Output=000 and Overflow=0 after the edge.
- Reset=0, En=1 for 7 edges -> Output steps 001, 011, 010, 110, 111, 101, 100. Overflow=0 throughout, and each step changes exactly one bit.
- From Output=100, one more enabled edge -> Output=000, Overflow=1. Eight further enabled edges -> Overflow stays 1 and Output returns to 000.
- En=0 for 5 edges at Output=011 -> Output stays 011 and Overflow unchanged. Re-assert En -> next edge gives 010.
- Reset=1 at Output=110 with Overflow=1 while En=1 -> next edge gives Output=000 and Overflow=0. Reset held for several edges keeps 000/0.
- Reset=1 and En=1 at the same edge as Output=100 -> Output=000, Overflow=0, showing reset has priority over the wrap.
